// File: rtl/enc_defines.sv
// Shared constants and FSM state encodings for the Exp-Golomb header parser.
package enc_defines;

  localparam int EG_MAX_LEN = 17;
  localparam int EG_MAX_LZ  = 8;
  localparam int EG_IN_W    = 32;
  localparam int EG_BUF_W   = 64;

  typedef enum logic [1:0] {
    EG_IDLE = 2'd0,
    EG_DEC  = 2'd1,
    EG_OUT  = 2'd2,
    EG_ERR  = 2'd3
  } eg_state_e;

endpackage

// File: rtl/mb_header_expgolomb_parser_if.sv
// Bundle of the word-feed, request and result channels of the Exp-Golomb parser.
interface mb_header_expgolomb_parser_if
  import enc_defines::*;
#(
  parameter int IN_W   = 32,
  parameter int FILL_W = 7
);
  // Every channel is valid/ready: a transfer happens on a rising clk edge where
  // both are high; a source holds valid and its payload stable until that edge.
  logic [IN_W-1:0]   s_data;
  logic              s_valid;
  logic              s_ready;
  logic              req_valid;
  logic              req_se;
  logic              req_ready;
  logic              out_valid;
  logic              out_ready;
  logic [8:0]        out_code;
  logic [8:0]        out_value;
  logic [4:0]        out_len;
  logic              out_err;
  eg_state_e         dbg_state;
  logic [FILL_W-1:0] dbg_fill;

  modport master (
    output s_data, s_valid, req_valid, req_se, out_ready,
    input  s_ready, req_ready, out_valid, out_code, out_value, out_len, out_err,
           dbg_state, dbg_fill
  );

  modport slave (
    input  s_data, s_valid, req_valid, req_se, out_ready,
    output s_ready, req_ready, out_valid, out_code, out_value, out_len, out_err,
           dbg_state, dbg_fill
  );
endinterface

// File: rtl/mb_header_lzc17.sv
// Combinational leading-zero count of a 17-bit window; all-zero input gives 17.
module mb_header_lzc17 (
  input  logic [16:0] din,
  output logic [4:0]  lz
);
  // Ascending scan: the highest set bit is the last one to write lz.
  always_comb begin
    lz = 5'd17;
    for (int i = 0; i < 17; i++) begin
      if (din[i]) lz = 5'(16 - i);
    end
  end
endmodule

// File: rtl/mb_header_expgolomb_parser.sv
// Exp-Golomb ue(v)/se(v) parser: MSB-aligned bit buffer fed by 32-bit words,
// one decoded codeword per request.
module mb_header_expgolomb_parser
  import enc_defines::*;
#(
  parameter int IN_W    = EG_IN_W,
  parameter int BUF_W   = EG_BUF_W,
  parameter int MAX_LEN = EG_MAX_LEN
) (
  input logic clk,
  input logic rst,
  mb_header_expgolomb_parser_if.slave bus
);
  localparam int FILL_W = $clog2(BUF_W + 1);

  logic [BUF_W-1:0]  bitbuf_q, bitbuf_d;
  logic [FILL_W-1:0] fill_q, fill_d;
  eg_state_e         state_q, state_d;
  logic              se_q, se_d;
  logic [8:0]        code_q, code_d, value_q, value_d;
  logic [4:0]        len_q, len_d;

  logic [MAX_LEN-1:0] window;
  logic [4:0]         lz;
  logic [4:0]         cw_len;
  logic               lz_ok;
  logic [8:0]         code_next, se_next;
  logic               consume, s_ready, req_ready, out_valid, out_err;
  logic [BUF_W-1:0]   shifted, word_ext;
  logic [FILL_W-1:0]  fill_c;

  assign window = bitbuf_q[BUF_W-1 -: MAX_LEN];

  mb_header_lzc17 u_lzc (
    .din (window),
    .lz  (lz)
  );

  // The codeword read as a binary number is codeNum + 1; only meaningful when lz_ok.
  assign lz_ok     = (lz <= 5'(EG_MAX_LZ));
  assign cw_len    = {lz[3:0], 1'b1};
  assign code_next = 9'((window >> (5'(MAX_LEN) - cw_len)) - MAX_LEN'(1));
  assign se_next   = code_next[0] ? ((code_next + 9'd1) >> 1) : (9'd0 - (code_next >> 1));

  assign s_ready  = (fill_q <= FILL_W'(BUF_W - IN_W)) && (state_q != EG_ERR);
  assign word_ext = {bus.s_data, {(BUF_W - IN_W){1'b0}}};

  always_comb begin
    state_d   = state_q;
    se_d      = se_q;
    code_d    = code_q;
    value_d   = value_q;
    len_d     = len_q;
    consume   = 1'b0;
    req_ready = 1'b0;
    out_valid = 1'b0;
    out_err   = 1'b0;
    case (state_q)
      EG_IDLE: begin
        req_ready = 1'b1;
        if (bus.req_valid) begin
          se_d    = bus.req_se;
          state_d = EG_DEC;
        end
      end
      EG_DEC: begin
        // Too many leading zeros is only conclusive once 9 zero bits are really present.
        if (!lz_ok && fill_q >= FILL_W'(EG_MAX_LZ + 1)) begin
          state_d = EG_ERR;
        end else if (lz_ok && fill_q >= FILL_W'(cw_len)) begin
          consume = 1'b1;
          code_d  = code_next;
          value_d = se_q ? se_next : code_next;
          len_d   = cw_len;
          state_d = EG_OUT;
        end
      end
      EG_OUT: begin
        out_valid = 1'b1;
        if (bus.out_ready) begin
          req_ready = 1'b1;
          if (bus.req_valid) begin
            se_d    = bus.req_se;
            state_d = EG_DEC;
          end else begin
            state_d = EG_IDLE;
          end
        end
      end
      EG_ERR: out_err = 1'b1;
      default: state_d = EG_IDLE;
    endcase
  end

  // Consume and word append share one cycle: the new word lands right after the
  // bits that survive the consume shift. Bits past fill are always zero.
  always_comb begin
    shifted = bitbuf_q;
    fill_c  = fill_q;
    if (consume) begin
      shifted = bitbuf_q << cw_len;
      fill_c  = fill_q - FILL_W'(cw_len);
    end
    bitbuf_d = shifted;
    fill_d   = fill_c;
    if (bus.s_valid && s_ready) begin
      bitbuf_d = shifted | (word_ext >> fill_c);
      fill_d   = fill_c + FILL_W'(IN_W);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bitbuf_q <= '0;
      fill_q   <= '0;
      state_q  <= EG_IDLE;
      se_q     <= 1'b0;
      code_q   <= '0;
      value_q  <= '0;
      len_q    <= '0;
    end else begin
      bitbuf_q <= bitbuf_d;
      fill_q   <= fill_d;
      state_q  <= state_d;
      se_q     <= se_d;
      code_q   <= code_d;
      value_q  <= value_d;
      len_q    <= len_d;
    end
  end

  assign bus.s_ready   = s_ready;
  assign bus.req_ready = req_ready;
  assign bus.out_valid = out_valid;
  assign bus.out_err   = out_err;
  assign bus.out_code  = code_q;
  assign bus.out_value = value_q;
  assign bus.out_len   = len_q;
  assign bus.dbg_state = state_q;
  assign bus.dbg_fill  = fill_q;
endmodule

// File: tb/tb_mb_header_expgolomb_parser.sv
// Directed bench for the Exp-Golomb parser: vector table of hand-computed codes
// plus sequences for straddling, back-pressure, streaming and reset.
module tb_mb_header_expgolomb_parser;
  import enc_defines::*;

  typedef struct {
    logic       se;
    logic [8:0] code;
    logic [8:0] value;
    logic [4:0] len;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mb_header_expgolomb_parser_if #(.IN_W(32), .FILL_W(7)) bus ();

  mb_header_expgolomb_parser dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  vec_t        tbl[10];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] word_q[$];
  bit          bits_q[$];
  int          accepted_words = 0;
  int          consumed_bits  = 0;

  // Word feeder: presents the head of word_q, pops it on a handshake.
  always @(negedge clk) begin
    if (word_q.size() > 0) begin
      bus.s_valid = 1'b1;
      bus.s_data  = word_q[0];
    end else begin
      bus.s_valid = 1'b0;
    end
  end

  always @(posedge clk) begin
    if (!rst && bus.s_valid && bus.s_ready) begin
      word_q.delete(0);
      accepted_words++;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Exp-Golomb encoder for stimulus: codeword bits are codeNum+1 in 2*lz+1 bits.
  function automatic void push_code(input logic [8:0] code);
    logic [16:0] n;
    int lz;
    n  = 17'(code) + 17'd1;
    lz = 0;
    for (int i = 0; i < 17; i++) if (n[i]) lz = i;
    for (int i = 2 * lz; i >= 0; i--) bits_q.push_back(n[i]);
  endfunction

  function automatic void flush_words();
    logic [31:0] w;
    while (bits_q.size() > 0) begin
      w = '0;
      for (int i = 0; i < 32; i++) begin
        w = {w[30:0], 1'b0};
        if (bits_q.size() > 0) w[0] = bits_q.pop_front();
      end
      word_q.push_back(w);
    end
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    word_q.delete();
    bits_q.delete();
    bus.req_valid = 1'b0;
    bus.req_se    = 1'b0;
    bus.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    accepted_words = 0;
    consumed_bits  = 0;
    rst = 1'b0;
    #1;
    chk("rst_s_ready",   32'(bus.s_ready),   32'd1);
    chk("rst_req_ready", 32'(bus.req_ready), 32'd1);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_err",   32'(bus.out_err),   32'd0);
    chk("rst_out_code",  32'(bus.out_code),  32'd0);
    chk("rst_out_value", 32'(bus.out_value), 32'd0);
    chk("rst_out_len",   32'(bus.out_len),   32'd0);
    chk("rst_fill",      32'(bus.dbg_fill),  32'd0);
  endtask

  task automatic issue_req(input logic se, input string name);
    bit ok;
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_se    = se;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      #1;
      if (bus.req_ready) ok = 1'b1;
      @(posedge clk);
      if (ok) break;
    end
    #1;
    bus.req_valid = 1'b0;
    chk({name, "_req_accepted"}, 32'(ok), 32'd1);
  endtask

  // Called at posedge+1 after the request handshake; lat counts edges to out_valid.
  task automatic wait_out(input vec_t v, input string name, input int hold, output int lat);
    lat = 0;
    while (!bus.out_valid && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    consumed_bits += int'(v.len);
    chk({name, "_valid"}, 32'(bus.out_valid), 32'd1);
    chk({name, "_code"},  32'(bus.out_code),  32'(v.code));
    chk({name, "_value"}, 32'(bus.out_value), 32'(v.value));
    chk({name, "_len"},   32'(bus.out_len),   32'(v.len));
    chk({name, "_fill"},  32'(bus.dbg_fill),  32'(32 * accepted_words - consumed_bits));
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      chk({name, "_hold_valid"}, 32'(bus.out_valid), 32'd1);
      chk({name, "_hold_code"},  32'(bus.out_code),  32'(v.code));
      chk({name, "_hold_value"}, 32'(bus.out_value), 32'(v.value));
      chk({name, "_hold_len"},   32'(bus.out_len),   32'(v.len));
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
  endtask

  task automatic do_req(input vec_t v, input string name, output int lat);
    issue_req(v.se, name);
    wait_out(v, name, 0, lat);
  endtask

  initial begin
    int   lat;
    int   n;
    int   last;
    logic [31:0] w2;
    vec_t v;

    // se values: odd codeNum -> +(c+1)/2, even -> -(c/2), 9-bit two's complement.
    tbl[0] = '{1'b1, 9'd0,   9'd0,     5'd1};
    tbl[1] = '{1'b1, 9'd1,   9'd1,     5'd3};
    tbl[2] = '{1'b1, 9'd2,   9'h1FF,   5'd3};
    tbl[3] = '{1'b1, 9'd3,   9'd2,     5'd5};
    tbl[4] = '{1'b0, 9'd7,   9'd7,     5'd7};
    tbl[5] = '{1'b1, 9'd4,   9'h1FE,   5'd5};
    tbl[6] = '{1'b1, 9'd255, 9'd128,   5'd17};
    tbl[7] = '{1'b0, 9'd14,  9'd14,    5'd7};
    tbl[8] = '{1'b1, 9'd6,   9'h1FD,   5'd5};
    tbl[9] = '{1'b1, 9'd510, 9'h101,   5'd17};

    bus.req_valid = 1'b0;
    bus.req_se    = 1'b0;
    bus.out_ready = 1'b0;

    // Single marker bit then a zero tail that must end in the sticky error state.
    do_reset();
    word_q.push_back(32'h8000_0000);
    do_req('{1'b0, 9'd0, 9'd0, 5'd1}, "t1_code0", lat);
    issue_req(1'b0, "t1_err");
    n = 0;
    while (!bus.out_err && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    bus.req_valid = 1'b1;
    #1;
    chk("t1_out_err",   32'(bus.out_err),   32'd1);
    chk("t1_out_valid", 32'(bus.out_valid), 32'd0);
    chk("t1_s_ready",   32'(bus.s_ready),   32'd0);
    chk("t1_req_ready", 32'(bus.req_ready), 32'd0);
    chk("t1_state",     32'(bus.dbg_state), 32'(EG_ERR));
    repeat (5) @(posedge clk);
    #1;
    chk("t1_err_sticky", 32'(bus.out_err), 32'd1);
    bus.req_valid = 1'b0;

    // Whole table as one stream, each request checked for 2-cycle latency.
    do_reset();
    for (int i = 0; i < 10; i++) push_code(tbl[i].code);
    flush_words();
    for (int i = 0; i < 10; i++) begin
      do_req(tbl[i], $sformatf("t2_vec%0d", i), lat);
      chk($sformatf("t2_lat%0d", i), 32'(lat), 32'd1);
    end

    // Max-length code in a single word.
    do_reset();
    push_code(9'd510);
    flush_words();
    do_req(tbl[9], "t3_whole", lat);

    // Same code split 5/12 across words: must wait (not error) on 5 zero bits.
    do_reset();
    for (int i = 0; i < 9; i++) push_code(9'd1);
    push_code(9'd510);
    flush_words();
    w2 = word_q.pop_back();
    for (int i = 0; i < 9; i++) do_req('{1'b0, 9'd1, 9'd1, 5'd3}, $sformatf("t3_pre%0d", i), lat);
    issue_req(1'b1, "t3_split");
    repeat (8) @(posedge clk);
    #1;
    chk("t3_wait_valid", 32'(bus.out_valid), 32'd0);
    chk("t3_wait_state", 32'(bus.dbg_state), 32'(EG_DEC));
    chk("t3_wait_fill",  32'(bus.dbg_fill),  32'd5);
    word_q.push_back(w2);
    wait_out(tbl[9], "t3_split", 0, lat);

    // Result held 10 cycles under back-pressure while the feeder keeps pushing.
    do_reset();
    for (int r = 0; r < 2; r++) for (int i = 0; i < 10; i++) push_code(tbl[i].code);
    flush_words();
    issue_req(tbl[0].se, "t4_first");
    wait_out(tbl[0], "t4_first", 10, lat);
    chk("t4_s_ready_low", 32'(bus.s_ready),     32'd0);
    chk("t4_fill_full",   32'(bus.dbg_fill),    32'd63);
    chk("t4_words_taken", 32'(accepted_words),  32'd2);
    chk("t4_word_held",   32'(bus.s_valid),     32'd1);
    for (int k = 1; k < 20; k++) do_req(tbl[k % 10], $sformatf("t4_vec%0d", k), lat);

    // Streaming: request and out_ready held high, one ue result every 2 cycles.
    do_reset();
    for (int r = 0; r < 2; r++) for (int i = 0; i < 10; i++) push_code(tbl[i].code);
    flush_words();
    @(negedge clk);
    bus.req_se    = 1'b0;
    bus.req_valid = 1'b1;
    bus.out_ready = 1'b1;
    n = 0;
    last = 0;
    for (int cyc = 0; cyc < 300 && n < 20; cyc++) begin
      @(posedge clk);
      #1;
      if (bus.out_valid) begin
        chk($sformatf("t5_code%0d", n),  32'(bus.out_code),  32'(tbl[n % 10].code));
        chk($sformatf("t5_value%0d", n), 32'(bus.out_value), 32'(tbl[n % 10].code));
        if (n > 0) chk($sformatf("t5_gap%0d", n), 32'(cyc - last), 32'd2);
        last = cyc;
        n++;
      end
    end
    bus.req_valid = 1'b0;
    bus.out_ready = 1'b0;
    chk("t5_count", 32'(n), 32'd20);

    // Reset while in DEC with 20 bits buffered, then a fresh stream.
    do_reset();
    push_code(9'd3);
    push_code(9'd7);
    for (int i = 0; i < 20; i++) push_code(9'd0);
    flush_words();
    do_req('{1'b0, 9'd3, 9'd3, 5'd5}, "t6_a", lat);
    do_req('{1'b0, 9'd7, 9'd7, 5'd7}, "t6_b", lat);
    chk("t6_fill20", 32'(bus.dbg_fill), 32'd20);
    @(negedge clk);
    bus.req_valid = 1'b1;
    @(posedge clk);
    #1;
    chk("t6_in_dec", 32'(bus.dbg_state), 32'(EG_DEC));
    @(negedge clk);
    rst = 1'b1;
    bus.req_valid = 1'b0;
    word_q.delete();
    @(posedge clk);
    #1;
    chk("t6_rst_fill",  32'(bus.dbg_fill),  32'd0);
    chk("t6_rst_valid", 32'(bus.out_valid), 32'd0);
    chk("t6_rst_err",   32'(bus.out_err),   32'd0);
    chk("t6_rst_state", 32'(bus.dbg_state), 32'(EG_IDLE));
    do_reset();
    for (int i = 0; i < 4; i++) push_code(tbl[i].code);
    flush_words();
    for (int i = 0; i < 4; i++) begin
      v = tbl[i];
      do_req(v, $sformatf("t6_fresh%0d", i), lat);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end
endmodule
